// File: rtl/sprite_pkg.sv
// Purpose: shared constants and types for the sprite pixel reader.
//   COORD_W/COLOR_W/DIM_LOG2/KEY_COLOR : default geometry and transparency key
//   pos_state_t                        : position handshake FSM states
//   PIPE_LAT                           : pixel-in to rgb-out latency in clk
package sprite_pkg;

  localparam int unsigned COORD_W  = 10;
  localparam int unsigned COLOR_W  = 12;
  localparam int unsigned DIM_LOG2 = 5;
  localparam logic [COLOR_W-1:0] KEY_COLOR = 12'hFFF;
  localparam int unsigned PIPE_LAT = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } pos_state_t;

endpackage

// File: rtl/sprite_pos_latch.sv
// Purpose: accepts a new sprite position through a valid/ready slot and applies
// it (plus the visibility request) only at frame_tick, so a frame never tears.
//   clk_i, reset_i          : clock, async active-high reset
//   frame_tick_i            : start-of-vblank pulse
//   pos_valid_i/pos_ready_o : position offer handshake
//   pos_x_i, pos_y_i        : offered top-left corner
//   sprite_en_i             : requested visibility, sampled at frame_tick
//   act_x_o, act_y_o, act_en_o : position/enable used by the current frame
module sprite_pos_latch
  import sprite_pkg::*;
#(
  parameter int unsigned        COORD_W = sprite_pkg::COORD_W,
  parameter logic [COORD_W-1:0] RESET_X = '0,
  parameter logic [COORD_W-1:0] RESET_Y = '0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               frame_tick_i,
  input  logic               pos_valid_i,
  output logic               pos_ready_o,
  input  logic [COORD_W-1:0] pos_x_i,
  input  logic [COORD_W-1:0] pos_y_i,
  input  logic               sprite_en_i,
  output logic [COORD_W-1:0] act_x_o,
  output logic [COORD_W-1:0] act_y_o,
  output logic               act_en_o
);

  pos_state_t         state_q;
  logic               ready_q;
  logic [COORD_W-1:0] pend_x_q, pend_y_q;
  logic [COORD_W-1:0] act_x_q, act_y_q;
  logic               act_en_q;

  // A capture in IDLE ignores a coincident tick; that value waits for the next one.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      pend_x_q <= '0;
      pend_y_q <= '0;
      act_x_q  <= RESET_X;
      act_y_q  <= RESET_Y;
      act_en_q <= 1'b0;
    end else begin
      if (frame_tick_i) act_en_q <= sprite_en_i;
      case (state_q)
        IDLE: begin
          if (pos_valid_i) begin
            pend_x_q <= pos_x_i;
            pend_y_q <= pos_y_i;
            state_q  <= PENDING;
            ready_q  <= 1'b0;
          end
        end
        PENDING: begin
          if (frame_tick_i) begin
            act_x_q <= pend_x_q;
            act_y_q <= pend_y_q;
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign pos_ready_o = ready_q;
  assign act_x_o     = act_x_q;
  assign act_y_o     = act_y_q;
  assign act_en_o    = act_en_q;

endmodule

// File: rtl/sprite_pixel_reader.sv
// Purpose: maps the raw VGA scan onto a movable, optionally scaled 32x32
// sprite ROM, realigns the ROM colour with the scan and keys it over bg_rgb.
//   clk, reset                 : pixel clock, async active-high reset
//   pixel_x/pixel_y/video_on/bg_rgb : scan inputs, mutually aligned
//   frame_tick, pos_*, sprite_en_in : position update interface
//   rom_row/rom_col -> rom_color    : synchronous-read ROM port
//   rgb_out, sprite_hit        : final colour, PIPE_LAT clk after the scan
module sprite_pixel_reader
  import sprite_pkg::*;
#(
  parameter int unsigned        COORD_W     = sprite_pkg::COORD_W,
  parameter int unsigned        COLOR_W     = sprite_pkg::COLOR_W,
  parameter int unsigned        DIM_LOG2    = sprite_pkg::DIM_LOG2,
  parameter int unsigned        SCALE_SHIFT = 0,
  parameter logic [COLOR_W-1:0] KEY_COLOR   = sprite_pkg::KEY_COLOR,
  parameter logic [COORD_W-1:0] RESET_X     = '0,
  parameter logic [COORD_W-1:0] RESET_Y     = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [COORD_W-1:0]  pixel_x,
  input  logic [COORD_W-1:0]  pixel_y,
  input  logic                video_on,
  input  logic [COLOR_W-1:0]  bg_rgb,
  input  logic                frame_tick,
  input  logic                pos_valid,
  output logic                pos_ready,
  input  logic [COORD_W-1:0]  pos_x,
  input  logic [COORD_W-1:0]  pos_y,
  input  logic                sprite_en_in,
  output logic [DIM_LOG2-1:0] rom_row,
  output logic [DIM_LOG2-1:0] rom_col,
  input  logic [COLOR_W-1:0]  rom_color,
  output logic [COLOR_W-1:0]  rgb_out,
  output logic                sprite_hit
);

  localparam int unsigned DW   = COORD_W + 1;
  localparam int unsigned SPAN = 1 << (DIM_LOG2 + SCALE_SHIFT);
  // Side-band stages before the output register (address reg + ROM reg).
  localparam int unsigned SB   = PIPE_LAT - 1;

  logic [COORD_W-1:0] act_x, act_y;
  logic               act_en;

  sprite_pos_latch #(
    .COORD_W (COORD_W),
    .RESET_X (RESET_X),
    .RESET_Y (RESET_Y)
  ) u_pos (
    .clk_i        (clk),
    .reset_i      (reset),
    .frame_tick_i (frame_tick),
    .pos_valid_i  (pos_valid),
    .pos_ready_o  (pos_ready),
    .pos_x_i      (pos_x),
    .pos_y_i      (pos_y),
    .sprite_en_i  (sprite_en_in),
    .act_x_o      (act_x),
    .act_y_o      (act_y),
    .act_en_o     (act_en)
  );

  // Stage 0: one extra bit makes a scan left of / above the sprite negative,
  // so the box test clips instead of wrapping to column/row 0.
  logic [DW-1:0] dx_d, dy_d;
  logic          in_box_d;

  assign dx_d = {1'b0, pixel_x} - {1'b0, act_x};
  assign dy_d = {1'b0, pixel_y} - {1'b0, act_y};
  assign in_box_d = act_en & video_on
                  & ~dx_d[DW-1] & ~dy_d[DW-1]
                  & (dx_d < DW'(SPAN)) & (dy_d < DW'(SPAN));

  logic [DIM_LOG2-1:0] rom_row_q, rom_col_q;
  logic [SB-1:0]       in_box_q, vid_q;
  logic [COLOR_W-1:0]  bg_q [SB];

  // Stage 1 address register and side-band delay line matching the ROM read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_row_q <= '0;
      rom_col_q <= '0;
      in_box_q  <= '0;
      vid_q     <= '0;
      for (int i = 0; i < int'(SB); i++) bg_q[i] <= '0;
    end else begin
      rom_row_q   <= in_box_d ? dy_d[SCALE_SHIFT +: DIM_LOG2] : '0;
      rom_col_q   <= in_box_d ? dx_d[SCALE_SHIFT +: DIM_LOG2] : '0;
      in_box_q[0] <= in_box_d;
      vid_q[0]    <= video_on;
      bg_q[0]     <= bg_rgb;
      for (int i = 1; i < int'(SB); i++) begin
        in_box_q[i] <= in_box_q[i-1];
        vid_q[i]    <= vid_q[i-1];
        bg_q[i]     <= bg_q[i-1];
      end
    end
  end

  logic [COLOR_W-1:0] rgb_q;
  logic               hit_q;

  // Stage 3: blank, opaque sprite texel, or background.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q <= '0;
      hit_q <= 1'b0;
    end else if (!vid_q[SB-1]) begin
      rgb_q <= '0;
      hit_q <= 1'b0;
    end else if (in_box_q[SB-1] && (rom_color != KEY_COLOR)) begin
      rgb_q <= rom_color;
      hit_q <= 1'b1;
    end else begin
      rgb_q <= bg_q[SB-1];
      hit_q <= 1'b0;
    end
  end

  assign rom_row    = rom_row_q;
  assign rom_col    = rom_col_q;
  assign rgb_out    = rgb_q;
  assign sprite_hit = hit_q;

endmodule

// File: tb/tb_sprite_pixel_reader.sv
module tb_sprite_pixel_reader;

  typedef struct {
    int          unit;
    logic [9:0]  px;
    logic [9:0]  py;
    logic        von;
    logic [11:0] bg;
    bit          ca;
    logic [4:0]  erow;
    logic [4:0]  ecol;
    bit          ck;
    logic [11:0] ergb;
    logic        ehit;
    int          id;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  pixel_x, pixel_y, pos_x, pos_y;
  logic        video_on, frame_tick, pos_valid, sprite_en_in;
  logic [11:0] bg_rgb;

  logic        ready0, ready1, hit0, hit1;
  logic [4:0]  row0, col0, row1, col1;
  logic [11:0] romc0, romc1, rgb0, rgb1;

  logic [11:0] rom_mem [32][32];

  int n_cmp = 0;
  int n_bad = 0;
  int vid   = 0;
  vec_t sb_q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  sprite_pixel_reader #(.SCALE_SHIFT(0)) dut (
    .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .bg_rgb(bg_rgb), .frame_tick(frame_tick),
    .pos_valid(pos_valid), .pos_ready(ready0), .pos_x(pos_x), .pos_y(pos_y),
    .sprite_en_in(sprite_en_in), .rom_row(row0), .rom_col(col0),
    .rom_color(romc0), .rgb_out(rgb0), .sprite_hit(hit0)
  );

  sprite_pixel_reader #(.SCALE_SHIFT(1)) dut_s1 (
    .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .bg_rgb(bg_rgb), .frame_tick(frame_tick),
    .pos_valid(1'b0), .pos_ready(ready1), .pos_x(10'd0), .pos_y(10'd0),
    .sprite_en_in(sprite_en_in), .rom_row(row1), .rom_col(col1),
    .rom_color(romc1), .rgb_out(rgb1), .sprite_hit(hit1)
  );

  // Synchronous-read ROM models.
  always @(posedge clk) begin
    romc0 <= rom_mem[row0][col0];
    romc1 <= rom_mem[row1][col1];
  end

  task automatic cmp(input string nm, input int id, input logic [11:0] act, input logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h, expected %h", nm, id, act, exp);
    end
  endtask

  function automatic vec_t mkv(input int unit, input int px, input int py, input bit von,
                               input logic [11:0] bg, input bit ca, input int er, input int ec,
                               input bit ck, input logic [11:0] ergb, input logic ehit);
    vec_t t;
    t.unit = unit; t.px = 10'(px); t.py = 10'(py); t.von = von; t.bg = bg;
    t.ca = ca; t.erow = 5'(er); t.ecol = 5'(ec);
    t.ck = ck; t.ergb = ergb; t.ehit = ehit;
    vid++;
    t.id = vid;
    return t;
  endfunction

  function automatic vec_t hitv(input int unit, input int px, input int py, input int r, input int c);
    return mkv(unit, px, py, 1'b1, 12'h0A5, 1'b1, r, c, 1'b1, rom_mem[r][c], 1'b1);
  endfunction

  function automatic vec_t missv(input int unit, input int px, input int py, input logic [11:0] bg);
    return mkv(unit, px, py, 1'b1, bg, 1'b1, 0, 0, 1'b1, bg, 1'b0);
  endfunction

  function automatic vec_t idlev();
    return mkv(0, 0, 0, 1'b0, 12'h000, 1'b0, 0, 0, 1'b0, 12'h000, 1'b0);
  endfunction

  // Drive one scan pixel at the falling edge; compare the output due 3 clk later.
  task automatic run(input vec_t t);
    vec_t e;
    pixel_x = t.px; pixel_y = t.py; video_on = t.von; bg_rgb = t.bg;
    sb_q.push_back(t);
    @(posedge clk);
    @(negedge clk);
    if (t.ca) begin
      cmp("rom_row", t.id, 12'(t.unit == 0 ? row0 : row1), 12'(t.erow));
      cmp("rom_col", t.id, 12'(t.unit == 0 ? col0 : col1), 12'(t.ecol));
    end
    if (sb_q.size() >= 3) begin
      e = sb_q.pop_front();
      if (e.ck) begin
        cmp("rgb_out", e.id, e.unit == 0 ? rgb0 : rgb1, e.ergb);
        cmp("sprite_hit", e.id, 12'(e.unit == 0 ? hit0 : hit1), 12'(e.ehit));
      end
    end
  endtask

  task automatic offer(input int x, input int y);
    pos_valid = 1'b1; pos_x = 10'(x); pos_y = 10'(y);
    run(idlev());
    pos_valid = 1'b0;
  endtask

  task automatic tick(input bit en);
    frame_tick = 1'b1; sprite_en_in = en;
    run(idlev());
    frame_tick = 1'b0;
  endtask

  initial begin
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++)
        rom_mem[r][c] = 12'(12'h100 + r * 64 + c);
    rom_mem[0][1] = 12'hFFF;
    rom_mem[0][2] = 12'h000;

    reset = 1'b1; pixel_x = '0; pixel_y = '0; video_on = 1'b0; bg_rgb = '0;
    frame_tick = 1'b0; pos_valid = 1'b0; pos_x = '0; pos_y = '0; sprite_en_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cmp("rst_rgb", 0, rgb0, 12'h000);
    cmp("rst_hit", 0, 12'(hit0), 12'h000);
    cmp("rst_ready", 0, 12'(ready0), 12'h001);
    cmp("rst_row", 0, 12'(row0), 12'h000);
    cmp("rst_col", 0, 12'(col0), 12'h000);
    reset = 1'b0;

    // Enable starts off: the reset position (0,0) draws nothing.
    run(missv(0, 0, 0, 12'h321));
    run(missv(1, 1, 1, 12'h321));
    offer(100, 50);
    cmp("ready_pending", 1, 12'(ready0), 12'h000);
    tick(1'b1);
    cmp("ready_applied", 1, 12'(ready0), 12'h001);

    // Basic hits, box edges, keying and blanking at (100,50); then scale-2 unit at (0,0).
    tbl.push_back(hitv(0, 100, 50, 0, 0));
    tbl.push_back(hitv(0, 131, 81, 31, 31));
    tbl.push_back(missv(0, 99, 50, 12'h0A0));
    tbl.push_back(missv(0, 132, 50, 12'h0B0));
    tbl.push_back(mkv(0, 101, 50, 1'b1, 12'h00F, 1'b1, 0, 1, 1'b1, 12'h00F, 1'b0));
    tbl.push_back(mkv(0, 102, 50, 1'b1, 12'h00F, 1'b1, 0, 2, 1'b1, 12'h000, 1'b1));
    tbl.push_back(mkv(0, 110, 60, 1'b0, 12'h777, 1'b1, 0, 0, 1'b1, 12'h000, 1'b0));
    tbl.push_back(missv(0, 100, 82, 12'h0C0));
    tbl.push_back(missv(0, 100, 49, 12'h0D0));
    tbl.push_back(hitv(0, 115, 70, 20, 15));
    tbl.push_back(hitv(1, 63, 63, 31, 31));
    tbl.push_back(missv(1, 64, 0, 12'h0E0));
    tbl.push_back(hitv(1, 0, 0, 0, 0));
    tbl.push_back(hitv(1, 2, 3, 1, 1));
    foreach (tbl[i]) run(tbl[i]);

    // Handshake: second offer while pending is dropped.
    offer(200, 10);
    cmp("ready_busy", 2, 12'(ready0), 12'h000);
    offer(300, 300);
    run(missv(0, 200, 10, 12'h456));
    cmp("ready_held", 2, 12'(ready0), 12'h000);
    tick(1'b1);
    cmp("ready_free", 2, 12'(ready0), 12'h001);
    run(hitv(0, 200, 10, 0, 0));
    run(missv(0, 300, 300, 12'h456));
    run(hitv(0, 205, 12, 2, 5));

    // Capture coincident with tick: applied only at the following tick.
    pos_valid = 1'b1; pos_x = 10'd400; pos_y = 10'd100; frame_tick = 1'b1;
    run(idlev());
    pos_valid = 1'b0; frame_tick = 1'b0;
    cmp("ready_coinc", 3, 12'(ready0), 12'h000);
    run(hitv(0, 200, 10, 0, 0));
    run(missv(0, 400, 100, 12'h111));
    tick(1'b1);
    cmp("ready_coinc2", 3, 12'(ready0), 12'h001);
    run(hitv(0, 400, 100, 0, 0));
    run(missv(0, 200, 10, 12'h111));

    // Right-edge clip: no wrap to column 0.
    offer(620, 0);
    tick(1'b1);
    run(hitv(0, 639, 0, 0, 19));
    run(missv(0, 0, 0, 12'h222));
    run(hitv(0, 651, 0, 0, 31));
    run(missv(0, 652, 0, 12'h222));

    // Async reset mid-scan, with a pending position and a lit output.
    offer(5, 5);
    run(hitv(0, 639, 0, 0, 19));
    run(hitv(0, 639, 0, 0, 19));
    run(hitv(0, 639, 0, 0, 19));
    #2 reset = 1'b1;
    #1;
    cmp("async_rgb", 4, rgb0, 12'h000);
    cmp("async_hit", 4, 12'(hit0), 12'h000);
    cmp("async_ready", 4, 12'(ready0), 12'h001);
    sb_q.delete();
    @(negedge clk);
    reset = 1'b0;
    run(missv(0, 639, 0, 12'h333));
    run(missv(0, 0, 0, 12'h333));
    tick(1'b1);
    run(hitv(0, 0, 0, 0, 0));
    run(hitv(0, 5, 5, 5, 5));
    run(missv(0, 639, 0, 12'h333));
    run(idlev());
    run(idlev());
    run(idlev());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
